// File: rtl/top_puf.sv
// Dual-core adder PUF emulation: two ripple-carry delay models with per-stage
// PDL config, a per-bit arbiter, and a two-stage free-running pipeline.
module puf_chain #(
  parameter int WIDTH = 32,
  parameter int DW    = 7
) (
  input  logic [WIDTH-1:0]         p_i,
  input  logic [WIDTH-1:0]         cfg_i,
  output logic [WIDTH-1:0][DW-1:0] dly_o
);
  logic [DW-1:0] acc;
  logic          prop;

  // A propagating lower stage hands its settle time up the chain; otherwise the chain restarts.
  always_comb begin
    acc   = '0;
    prop  = 1'b0;
    dly_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc      = DW'(1) + DW'(cfg_i[i]) + (prop ? acc : '0);
      dly_o[i] = acc;
      prop     = p_i[i];
    end
  end
endmodule

module top_puf #(
  parameter int WIDTH = 32,
  parameter int DW    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] config1,
  input  logic [WIDTH-1:0] config2,
  output logic [WIDTH-1:0] c
);
  typedef struct packed {
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [1:0][WIDTH-1:0] cfg;
  } req_t;

  req_t                            req_d, req_q;
  logic [WIDTH-1:0]                p;
  logic [1:0][WIDTH-1:0][DW-1:0]   dly;
  logic [WIDTH-1:0]                r, c_d, c_q;

  always_comb begin
    req_d.a      = a;
    req_d.b      = b;
    req_d.cfg[0] = config1;
    req_d.cfg[1] = config2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req_q <= '0;
    else        req_q <= req_d;
  end

  assign p = req_q.a ^ req_q.b;

  for (genvar k = 0; k < 2; k++) begin : g_core
    puf_chain #(.WIDTH(WIDTH), .DW(DW)) u_chain (
      .p_i  (p),
      .cfg_i(req_q.cfg[k]),
      .dly_o(dly[k])
    );
  end

  // Strict compare: a tie resolves to 0, so identical cores always answer 0.
  for (genvar i = 0; i < WIDTH; i++) begin : g_arb
    assign r[i] = (dly[0][i] < dly[1][i]);
  end

  assign c_d = r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) c_q <= '0;
    else        c_q <= c_d;
  end

  assign c = c_q;
endmodule

// File: tb/tb_top_puf.sv
// Scoreboard bench for top_puf: expected responses are queued at drive time
// from a reference delay model and popped when the pipeline delivers them.
module tb_top_puf;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b, config1, config2;
  logic [31:0] c;

  top_puf dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .config1(config1),
    .config2(config2),
    .c      (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  // Settle time of bit i: walk down through propagating stages, summing stage costs.
  function automatic int settle(logic [31:0] p, logic [31:0] cfg, int i);
    int d = 1 + int'(cfg[i]);
    int j = i;
    while (j > 0 && p[j-1]) begin
      j--;
      d += 1 + int'(cfg[j]);
    end
    return d;
  endfunction

  function automatic logic [31:0] model(logic [31:0] ma, logic [31:0] mb,
                                        logic [31:0] mc1, logic [31:0] mc2);
    logic [31:0] p = ma ^ mb;
    logic [31:0] res = '0;
    for (int i = 0; i < 32; i++)
      res[i] = settle(p, mc1, i) < settle(p, mc2, i);
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s c=%h expected=%h", tag, act, exp);
  endtask

  task automatic pop_check();
    sb_t e;
    e = q.pop_front();
    check(e.tag, c, e.exp);
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vc1, input logic [31:0] vc2,
                       input logic [31:0] exp, input string tag);
    @(negedge clk);
    a = va; b = vb; config1 = vc1; config2 = vc2;
    q.push_back('{exp, tag});
    @(posedge clk); #1;
    if (q.size() == 2) pop_check();
  endtask

  task automatic flush();
    @(posedge clk); #1;
    if (q.size() > 0) pop_check();
  endtask

  initial begin
    logic [31:0] ra, rb, rc1, rc2;
    reset = 1'b0; a = '0; b = '0; config1 = '0; config2 = '0;
    #1 check("rst_init", c, 32'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    drive(32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, "equal_cfg");
    flush();
    drive(32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, "no_prop");
    flush();
    drive(32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, "no_prop_swap");
    flush();
    drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFF, "full_chain");
    flush();
    drive(32'h0, 32'h0, 32'h0, 32'h00000001, 32'h00000001, "chain_off");
    flush();
    drive(32'h0000000F, 32'h0, 32'h00000010, 32'h00000001, 32'h0000000F, "tie_break");
    flush();

    // Back-to-back samples: each response lands exactly two edges after its inputs.
    drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFF, "stream0");
    drive(32'h0, 32'h0, 32'h0, 32'h00000001, 32'h00000001, "stream1");
    drive(32'h0000000F, 32'h0, 32'h00000010, 32'h00000001, 32'h0000000F, "stream2");
    drive(32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, "stream3");
    flush();

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom; rc1 = $urandom;
      drive(ra, rb, rc1, rc1, 32'h0, $sformatf("sym%0d", i));
    end
    flush();

    for (int i = 0; i < 8; i++) begin
      ra = $urandom; rb = $urandom; rc1 = $urandom; rc2 = $urandom;
      if (i[0]) rb = ~ra ^ (32'h1 << i);
      drive(ra, rb, rc1, rc2, model(ra, rb, rc1, rc2), $sformatf("rand%0d", i));
    end
    flush();

    // Asynchronous reset while c holds a nonzero response.
    drive(32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, "pre_rst");
    flush();
    @(negedge clk); #2;
    reset = 1'b0;
    #1 check("rst_async", c, 32'h0);
    @(posedge clk); #1 check("rst_hold", c, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1 check("rst_release", c, 32'h0);
    drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h00000001, 32'hFFFFFFFF, "post_rst");
    flush();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
